// File: rtl/sequence_detector_1011_pkg.sv
`default_nettype none
// ============================================================================
// seq_det_pkg : constants, state-width helper and KMP next-state builder
// Revision    : 1.0
// ============================================================================
package seq_det_pkg;

  localparam int         SEQ_DET_MAX_LEN         = 16;
  localparam int         SEQ_DET_DEFAULT_LEN     = 4;
  localparam logic [3:0] SEQ_DET_DEFAULT_PATTERN = 4'b1011;

  // Progress states of the default 1011 detector.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } seq_det_state_e;

  function automatic int seq_det_state_w(input int len);
    return $clog2(len + 1);
  endfunction

  // Longest pattern prefix that is a suffix of (current prefix, x).
  // The received history is held LSB-newest in an integer shift image.
  function automatic int seq_det_next(input logic [15:0] pat, input int len,
                                      input bit overlap, input int k, input bit x);
    int unsigned p;
    int unsigned seq;
    int unsigned mask;
    int          m;
    int          best;
    p = 32'(pat);
    if (k >= len) begin
      if (overlap) begin
        seq = p & ((32'd1 << (len - 1)) - 32'd1);
        m   = len - 1;
      end else begin
        seq = 32'd0;
        m   = 0;
      end
    end else begin
      seq = p >> (len - k);
      m   = k;
    end
    seq  = (seq << 1) | 32'(x);
    m    = m + 1;
    best = 0;
    for (int j = 1; j <= len; j++) begin
      mask = (32'd1 << j) - 32'd1;
      if ((j <= m) && (((seq ^ (p >> (len - j))) & mask) == 32'd0)) begin
        best = j;
      end
    end
    return best;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sequence_detector_1011_if.sv
`default_nettype none
// ============================================================================
// sequence_detector_1011_if : serial data in / match flag out
// Revision : 1.0
// ============================================================================
interface sequence_detector_1011_if;
  logic x;
  logic z;

  modport master (output x, input  z);
  modport slave  (input  x, output z);
endinterface
`default_nettype wire

// File: rtl/sequence_detector_1011.sv
`default_nettype none
// ============================================================================
// sequence_detector_1011 : Moore serial pattern detector, elaborated KMP table
// Revision : 1.0
// ============================================================================
module sequence_detector_1011
  import seq_det_pkg::*;
#(
  parameter int LEN     = SEQ_DET_DEFAULT_LEN,
  parameter     PATTERN = SEQ_DET_DEFAULT_PATTERN,
  parameter int OVERLAP = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  sequence_detector_1011_if.slave  bus
);

  localparam int              C_SW    = seq_det_state_w(LEN);
  localparam int              C_DEPTH = 1 << C_SW;
  localparam logic [15:0]     C_PAT   = 16'(PATTERN);
  localparam logic [C_SW-1:0] C_LAST  = C_SW'(LEN);

  if ((LEN < 2) || (LEN > SEQ_DET_MAX_LEN)) begin : g_bad_len
    $fatal(1, "sequence_detector_1011: LEN out of range 2..16");
  end
  if ($bits(PATTERN) != LEN) begin : g_bad_pattern
    $fatal(1, "sequence_detector_1011: PATTERN width differs from LEN");
  end

  // Table is padded to a power of two so unreachable codes fall back to 0.
  logic [C_SW-1:0] next_tbl [C_DEPTH][2];

  for (genvar k = 0; k < C_DEPTH; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int C_NEXT = (k <= LEN)
                            ? seq_det_next(C_PAT, LEN, OVERLAP != 0, k, b != 0)
                            : 0;
      assign next_tbl[k][b] = C_SW'(C_NEXT);
    end
  end

  logic [C_SW-1:0] ps_q;
  logic [C_SW-1:0] ps_d;
  logic            z_q;

  always_comb begin
    ps_d = next_tbl[ps_q][bus.x];
  end

  // z_q tracks (ps_q == LEN) one-for-one, but comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q <= '0;
      z_q  <= 1'b0;
    end else begin
      ps_q <= ps_d;
      z_q  <= (ps_d == C_LAST);
    end
  end

  assign bus.z = z_q;

endmodule
`default_nettype wire

// File: tb/tb_sequence_detector_1011.sv
`default_nettype none
// ============================================================================
// tb_sequence_detector_1011 : directed vectors for default, non-overlap, 111
// Revision : 1.0
// ============================================================================
module tb_sequence_detector_1011;
  import seq_det_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  sequence_detector_1011_if if0 ();
  sequence_detector_1011_if if1 ();
  sequence_detector_1011_if if2 ();

  sequence_detector_1011 u0 (.clk(clk), .reset(reset), .bus(if0));

  sequence_detector_1011 #(.LEN(4), .PATTERN(4'b1011), .OVERLAP(0))
    u1 (.clk(clk), .reset(reset), .bus(if1));

  sequence_detector_1011 #(.LEN(3), .PATTERN(3'b111), .OVERLAP(1))
    u2 (.clk(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic xv);
    @(negedge clk);
    if0.x = xv;
    if1.x = xv;
    if2.x = xv;
    @(posedge clk);
    #1;
  endtask

  // One sampled bit on all instances; checks the default detector.
  task automatic step(input logic xv, input logic ez, input seq_det_state_e eps,
                      input string tag);
    drive(xv);
    check({tag, "_z"},  32'(if0.z),   32'(ez));
    check({tag, "_ps"}, 32'(u0.ps_q), 32'(eps));
  endtask

  // One sampled bit on all instances; checks the two variants.
  task automatic step_var(input logic xv, input logic ez1, input logic ez2,
                          input string tag);
    drive(xv);
    check({tag, "_z_noovl"}, 32'(if1.z), 32'(ez1));
    check({tag, "_z_111"},   32'(if2.z), 32'(ez2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    if0.x  = 1'b0;
    if1.x  = 1'b0;
    if2.x  = 1'b0;

    // Reset held two edges with x toggling, then a plain 1011.
    step(1'b1, 1'b0, S0, "rst_e1");
    step(1'b0, 1'b0, S0, "rst_e2");
    reset = 1'b0;
    step(1'b1, 1'b0, S1, "a_b1");
    step(1'b0, 1'b0, S2, "a_b2");
    step(1'b1, 1'b0, S3, "a_b3");
    step(1'b1, 1'b1, S4, "a_b4");
    step(1'b0, 1'b0, S2, "a_b5");

    // Overlap: 1011011
    reset = 1'b1;
    step(1'b0, 1'b0, S0, "ovl_rst");
    reset = 1'b0;
    step(1'b1, 1'b0, S1, "ovl_b1");
    step(1'b0, 1'b0, S2, "ovl_b2");
    step(1'b1, 1'b0, S3, "ovl_b3");
    step(1'b1, 1'b1, S4, "ovl_b4");
    step(1'b0, 1'b0, S2, "ovl_b5");
    step(1'b1, 1'b0, S3, "ovl_b6");
    step(1'b1, 1'b1, S4, "ovl_b7");

    // Continuation: 10111011
    reset = 1'b1;
    step(1'b0, 1'b0, S0, "cont_rst");
    reset = 1'b0;
    step(1'b1, 1'b0, S1, "cont_b1");
    step(1'b0, 1'b0, S2, "cont_b2");
    step(1'b1, 1'b0, S3, "cont_b3");
    step(1'b1, 1'b1, S4, "cont_b4");
    step(1'b1, 1'b0, S1, "cont_b5");
    step(1'b0, 1'b0, S2, "cont_b6");
    step(1'b1, 1'b0, S3, "cont_b7");
    step(1'b1, 1'b1, S4, "cont_b8");

    // Near-miss: 100101011
    reset = 1'b1;
    step(1'b0, 1'b0, S0, "nm_rst");
    reset = 1'b0;
    step(1'b1, 1'b0, S1, "nm_b1");
    step(1'b0, 1'b0, S2, "nm_b2");
    step(1'b0, 1'b0, S0, "nm_b3");
    step(1'b1, 1'b0, S1, "nm_b4");
    step(1'b0, 1'b0, S2, "nm_b5");
    step(1'b1, 1'b0, S3, "nm_b6");
    step(1'b0, 1'b0, S2, "nm_b7");
    step(1'b1, 1'b0, S3, "nm_b8");
    step(1'b1, 1'b1, S4, "nm_b9");

    // Reset mid-pattern discards 101 progress; reset wins over x=1.
    reset = 1'b1;
    step(1'b0, 1'b0, S0, "mid_rst0");
    reset = 1'b0;
    step(1'b1, 1'b0, S1, "mid_b1");
    step(1'b0, 1'b0, S2, "mid_b2");
    step(1'b1, 1'b0, S3, "mid_b3");
    reset = 1'b1;
    step(1'b1, 1'b0, S0, "mid_rst1");
    reset = 1'b0;
    step(1'b1, 1'b0, S1, "mid_b4");

    // Variants on 1011011: non-overlap hits once; 111 never hits.
    reset = 1'b1;
    step_var(1'b0, 1'b0, 1'b0, "v1_rst");
    reset = 1'b0;
    step_var(1'b1, 1'b0, 1'b0, "v1_b1");
    step_var(1'b0, 1'b0, 1'b0, "v1_b2");
    step_var(1'b1, 1'b0, 1'b0, "v1_b3");
    step_var(1'b1, 1'b1, 1'b0, "v1_b4");
    step_var(1'b0, 1'b0, 1'b0, "v1_b5");
    step_var(1'b1, 1'b0, 1'b0, "v1_b6");
    step_var(1'b1, 1'b0, 1'b0, "v1_b7");

    // Variants on 111110: 111 detector holds z for three cycles.
    reset = 1'b1;
    step_var(1'b0, 1'b0, 1'b0, "v2_rst");
    reset = 1'b0;
    step_var(1'b1, 1'b0, 1'b0, "v2_b1");
    step_var(1'b1, 1'b0, 1'b0, "v2_b2");
    step_var(1'b1, 1'b0, 1'b1, "v2_b3");
    step_var(1'b1, 1'b0, 1'b1, "v2_b4");
    step_var(1'b1, 1'b0, 1'b1, "v2_b5");
    step_var(1'b0, 1'b0, 1'b0, "v2_b6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sequence_detector_1011.md
# sequence_detector_1011

Serial bit-pattern detector: samples one input bit per clock and asserts a registered (Moore) match flag for one cycle after the last bit of the configured pattern arrives. Overlapping matches are detected by default. The default pattern is 1011. It sits directly on a serial data line and feeds downstream event or counter logic.

## Interface
- `LEN`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN`, default 4'b1011: pattern to detect, `LEN` bits wide; the MSB is the first bit received.
- `OVERLAP`, default 1: 1 means overlapping matches are detected; 0 means matching restarts from scratch after each hit.
- `clk`, input, 1: the single clock; every register updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `x`, input, 1: serial data bit, sampled on every rising `clk`.
- `z`, output, 1: match flag, registered; 1 for exactly the cycle after the final pattern bit is sampled.

## Operation
- State register `Ps`, `$clog2(LEN+1)` bits wide, holds the match-progress index k, with 0 ≤ k ≤ LEN.
  - k counts how many leading bits of `PATTERN` equal the most recent k received bits.
- Next state: the largest j ≤ LEN such that the first j pattern bits equal the last j bits of the current prefix followed by `x`.
  - This is the KMP failure-function rule.
  - Compute it at elaboration with a constant function. Do not hand-code it.
- Case k == LEN with `OVERLAP`=1: next state is computed from the full pattern with its first bit dropped, then `x` appended.
- Case k == LEN with `OVERLAP`=0: next state is computed as if from state 0.
- `z` = (`Ps` == LEN). This is a pure Moore output with no combinational path from `x`.
- Default 1011 transitions, listed as (state, x=0 → next, x=1 → next):
  - S0: 0→S0, 1→S1
  - S1: 0→S2, 1→S1
  - S2: 0→S0, 1→S3
  - S3: 0→S2, 1→S4
  - S4 (z=1): 0→S2, 1→S1
- Reset: on a rising edge with `reset`=1, `Ps` goes to S0, so `z`=0 in the next cycle.
  - Reset overrides `x`.
  - A reset mid-pattern discards the partial match.
- Reset values: `Ps`=0, `z`=0.

## Timing
- Latency: `z` rises one clock after the edge that samples the final pattern bit, and stays high for exactly one cycle unless the next bits complete another match.
- Back-to-back matches are possible only when the pattern's self-overlap allows them. For 1011 the minimum spacing between hits is 3 cycles (1011011).
- `x` must be stable around each rising edge; no handshake and no enable.
- An X/Z on `x` outside reset is undefined input; no recovery requirement.

## Structure
- Shared package `seq_det_pkg`:
  - default pattern and length constants `SEQ_DET_DEFAULT_PATTERN` and `SEQ_DET_DEFAULT_LEN`;
  - the constant function computing the next-state table;
  - `$clog2`-based state-width helper.
- Single module with no sub-module.
  - Next-state logic is a generated lookup, table[LEN+1][2], built in a `generate`/initial constant context.
  - One `always` block for the state register; `z` is a decode of `Ps`.
- Parameter checks at elaboration:
  - `LEN` within range;
  - `PATTERN` width consistent with `LEN`.

## Test plan
- Reset: hold `reset`=1 for 2 edges with `x` toggling → `Ps`=0 and `z`=0 throughout; release and apply 1,0,1,1 → `z`=1 for exactly the one cycle after the 4th sampled edge.
- Overlap: stream 1,0,1,1,0,1,1 → `z` pulses after bit 4 and after bit 7, and is 0 everywhere else.
- Continuation: stream 1,0,1,1,1,0,1,1 → `z` pulses after bit 4 and after bit 8; the state goes S4→S1 on the 5th bit.
- Near-miss: stream 1,0,0,1,0,1,0,1,1 → a single `z` pulse after bit 9; states S2→S0 on bit 3 and S3→S2 on bit 7.
- Reset mid-pattern: 1,0,1, then `reset`=1 for one edge, then 1 → no `z`; `Ps`=S1 afterwards.
- Parameter variant: `OVERLAP`=0 with 1,0,1,1,0,1,1 → single `z` after bit 4 only. Separately, `LEN`=3 and `PATTERN`=3'b111 with five consecutive 1s → `z` high for 3 consecutive cycles.
